// File: rtl/rst_seq_sync.sv
// Reset sequencer: synchronises the board reset into CLK, then releases NUM_RST
// active-low resets in order after a hold time, with a software re-sequence request.
module rst_seq_sync #(
    parameter int NUM_STAGES  = 2,
    parameter int NUM_RST     = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               SW_RST_REQ,
    output logic [NUM_RST-1:0] SYNC_RST,
    output logic               RST_DONE
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(NUM_RST + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_RST - 1);

    typedef enum logic [1:0] {
        ST_WAIT_SYNC = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    logic [NUM_STAGES-1:0] sync_r;
    logic                  sync_n_s;
    state_t                state_r, state_s;
    logic [CW-1:0]         cnt_r, cnt_s;
    logic [IW-1:0]         idx_r, idx_s;
    logic [NUM_RST-1:0]    sync_rst_r, sync_rst_s;
    logic                  done_r, done_s;

    assign sync_n_s = sync_r[NUM_STAGES-1];

    // Reset synchroniser chain: asserts asynchronously, releases after NUM_STAGES edges.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_r <= {NUM_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[NUM_STAGES-2:0], 1'b1};
        end
    end

    // Sequencer state, counter, index and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r    <= ST_WAIT_SYNC;
            cnt_r      <= {CW{1'b0}};
            idx_r      <= {IW{1'b0}};
            sync_rst_r <= {NUM_RST{1'b0}};
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            idx_r      <= idx_s;
            sync_rst_r <= sync_rst_s;
            done_r     <= done_s;
        end
    end

    // Next-state logic; a software request always beats a release on the same edge.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        idx_s      = idx_r;
        sync_rst_s = sync_rst_r;
        done_s     = done_r;
        case (state_r)
            ST_WAIT_SYNC: begin
                sync_rst_s = {NUM_RST{1'b0}};
                done_s     = 1'b0;
                cnt_s      = {CW{1'b0}};
                idx_s      = {IW{1'b0}};
                if (sync_n_s) begin
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_WAIT_SYNC;
                end
            end
            ST_HOLD: begin
                sync_rst_s = {NUM_RST{1'b0}};
                done_s     = 1'b0;
                if (SW_RST_REQ) begin
                    cnt_s = {CW{1'b0}};
                end else if (cnt_r == HOLD_LAST) begin
                    sync_rst_s = NUM_RST'(1'b1);
                    idx_s      = IW'(1);
                    cnt_s      = {CW{1'b0}};
                    if (NUM_RST == 1) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_RELEASE;
                    end
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            ST_RELEASE: begin
                if (SW_RST_REQ) begin
                    sync_rst_s = {NUM_RST{1'b0}};
                    done_s     = 1'b0;
                    cnt_s      = {CW{1'b0}};
                    idx_s      = {IW{1'b0}};
                    state_s    = ST_HOLD;
                end else if (cnt_r == GAP_LAST) begin
                    // Thermometer shift releases exactly bit idx_r.
                    sync_rst_s = (sync_rst_r << 1) | NUM_RST'(1'b1);
                    idx_s      = idx_r + IW'(1);
                    cnt_s      = {CW{1'b0}};
                    if (idx_r == LAST_IDX) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_RELEASE;
                    end
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            ST_DONE: begin
                if (SW_RST_REQ) begin
                    sync_rst_s = {NUM_RST{1'b0}};
                    done_s     = 1'b0;
                    cnt_s      = {CW{1'b0}};
                    idx_s      = {IW{1'b0}};
                    state_s    = ST_HOLD;
                end else begin
                    sync_rst_s = {NUM_RST{1'b1}};
                    done_s     = 1'b1;
                end
            end
            default: begin
                state_s    = ST_WAIT_SYNC;
                cnt_s      = {CW{1'b0}};
                idx_s      = {IW{1'b0}};
                sync_rst_s = {NUM_RST{1'b0}};
                done_s     = 1'b0;
            end
        endcase
    end

    assign SYNC_RST = sync_rst_r;
    assign RST_DONE = done_r;

endmodule
